// File: rtl/dbus_responder_if.sv
// Data-bus port between the core's MEM stage and dbus_responder, plus the TX
// byte stream and the status outputs.
interface dbus_responder_if #(
  parameter int XLEN = 32
);
  logic            mem_load;
  logic            mem_store;
  logic [XLEN-1:0] address;
  logic [XLEN-1:0] store_data;
  logic [XLEN-1:0] load_data;
  logic            tx_valid;
  logic [7:0]      tx_data;
  logic            tx_ready;
  logic            timer_irq;
  logic            bus_err;

  // Core / bench side.
  modport master (
    output mem_load, mem_store, address, store_data, tx_ready,
    input  load_data, tx_valid, tx_data, timer_irq, bus_err
  );

  // Responder side.
  modport slave (
    input  mem_load, mem_store, address, store_data, tx_ready,
    output load_data, tx_valid, tx_data, timer_irq, bus_err
  );
endinterface

// File: rtl/dbus_responder.sv
// dbus_responder: zero-wait data-bus responder. Decodes a word RAM at address 0
// and one MMIO page holding a byte TX FIFO and, optionally, a machine timer.
// Optional feature macro: DBUS_TIMER_EN (mtime/mtimecmp/timer_irq present).
module dbus_responder #(
  parameter int          XLEN       = 32,
  parameter int          RAM_WORDS  = 1024,
  parameter logic [63:0] MMIO_BASE  = 64'h1000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input logic               clock,
  input logic               reset,
  dbus_responder_if.slave   bus
);
  localparam int W      = XLEN / 8;
  localparam int WB     = $clog2(W);
  localparam int RAM_AW = $clog2(RAM_WORDS * W);
  localparam int IW     = $clog2(RAM_WORDS);
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int CW     = PW + 1;
  localparam int RW     = 8 - WB;
  localparam logic [XLEN-1:0] RAM_LIMIT = XLEN'(RAM_WORDS * W);

  localparam logic [RW-1:0] IDX_TXDATA = RW'(0);
  localparam logic [RW-1:0] IDX_TXSTAT = RW'(1);
`ifdef DBUS_TIMER_EN
  localparam logic [RW-1:0] IDX_MTLO   = RW'(2);
  localparam logic [RW-1:0] IDX_MTHI   = RW'(3);
  localparam logic [RW-1:0] IDX_CMPLO  = RW'(4);
  localparam logic [RW-1:0] IDX_CMPHI  = RW'(5);
  localparam logic [RW-1:0] IDX_LAST   = IDX_CMPHI;
`else
  localparam logic [RW-1:0] IDX_LAST   = IDX_TXSTAT;
`endif

  // ---------------- decode ----------------
  logic          acc, wr, ram_hit, mmio_hit, reg_mapped;
  logic [RW-1:0] reg_idx;
  logic [IW-1:0] ram_idx;
  logic          wr_tx, wr_stat;

  assign acc        = bus.mem_load | bus.mem_store;
  assign wr         = bus.mem_store;
  assign ram_hit    = bus.address < RAM_LIMIT;
  assign mmio_hit   = bus.address[XLEN-1:8] == MMIO_BASE[XLEN-1:8];
  assign reg_idx    = bus.address[7:WB];
  assign ram_idx    = bus.address[RAM_AW-1:WB];
  // RAM wins if a parameterisation ever overlaps the two regions.
  assign reg_mapped = mmio_hit && !ram_hit && (reg_idx <= IDX_LAST);
  assign wr_tx      = wr && reg_mapped && (reg_idx == IDX_TXDATA);
  assign wr_stat    = wr && reg_mapped && (reg_idx == IDX_TXSTAT);

  // ---------------- RAM ----------------
  logic [XLEN-1:0] ram_q [RAM_WORDS];

  // RAM write; deliberately outside reset so a store in the reset cycle lands.
  always_ff @(posedge clock) begin
    if (wr && ram_hit) ram_q[ram_idx] <= bus.store_data;
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          full, empty, pop, push_ok;

  assign full    = count_q == CW'(FIFO_DEPTH);
  assign empty   = count_q == '0;
  assign pop     = !empty && bus.tx_ready;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign push_ok = wr_tx && (!full || pop);

  // FIFO pointer/count/overflow next state.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (push_ok) wptr_d = wptr_q + PW'(1);
    if (pop)     rptr_d = rptr_q + PW'(1);
    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push_ok) count_d = count_q - CW'(1);
    if (wr_stat)                ovf_d = 1'b0;
    if (wr_tx && full && !pop)  ovf_d = 1'b1;
  end

  // FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge clock) begin
    if (push_ok) fifo_q[wptr_q] <= bus.store_data[7:0];
  end

  assign bus.tx_valid = !empty;
  assign bus.tx_data  = fifo_q[rptr_q];

  // ---------------- timer ----------------
`ifdef DBUS_TIMER_EN
  logic [63:0] mtime_q, mtime_d, mtcmp_q, mtcmp_d;
  logic        timer_irq_q, timer_irq_d;

  // mtime free-runs; a store to either half replaces it and skips the increment.
  always_comb begin
    mtime_d     = mtime_q + 64'd1;
    mtcmp_d     = mtcmp_q;
    timer_irq_d = mtime_q >= mtcmp_q;
    if (wr && reg_mapped) begin
      unique case (reg_idx)
        IDX_MTLO:  begin mtime_d = mtime_q; mtime_d[XLEN-1:0] = bus.store_data;       end
        IDX_MTHI:  begin mtime_d = mtime_q; mtime_d[63:32]    = bus.store_data[31:0]; end
        IDX_CMPLO: mtcmp_d[XLEN-1:0] = bus.store_data;
        IDX_CMPHI: mtcmp_d[63:32]    = bus.store_data[31:0];
        default: ;
      endcase
    end
  end

  // Timer state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      mtime_q     <= '0;
      mtcmp_q     <= '1;
      timer_irq_q <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      mtcmp_q     <= mtcmp_d;
      timer_irq_q <= timer_irq_d;
    end
  end

  assign bus.timer_irq = timer_irq_q;
`else
  assign bus.timer_irq = 1'b0;
`endif

  // ---------------- read mux / error ----------------
  logic [XLEN-1:0] rdata;
  logic            bus_err_q, bus_err_d;

  // Combinational read data; store cycles also return old data for RMW.
  always_comb begin
    rdata = '0;
    if (ram_hit) begin
      rdata = ram_q[ram_idx];
    end else if (reg_mapped) begin
      unique case (reg_idx)
        IDX_TXSTAT: rdata = XLEN'({8'(count_q), 5'b0, ovf_q, empty, full});
`ifdef DBUS_TIMER_EN
        IDX_MTLO:   rdata = mtime_q[XLEN-1:0];
        IDX_MTHI:   rdata = XLEN'(mtime_q[63:32]);
        IDX_CMPLO:  rdata = mtcmp_q[XLEN-1:0];
        IDX_CMPHI:  rdata = XLEN'(mtcmp_q[63:32]);
`endif
        default:    rdata = '0;
      endcase
    end
  end

  assign bus.load_data = acc ? rdata : '0;
  assign bus_err_d     = acc && !(ram_hit || reg_mapped);
  assign bus.bus_err   = bus_err_q;

  // MMIO state registers; reset discards queued bytes and same-cycle MMIO stores.
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      bus_err_q <= bus_err_d;
    end
  end
endmodule
